// File: rtl/lms_spi_sched.sv
// lms_spi_sched: two-port round-robin SPI transaction scheduler for the shared
// board SPI bus. One 16-bit word per transaction, MSB first, idle-low SCLK,
// active-low per-target enables.
// Optional feature macro: LMS_SPI_READBACK_EN (MISO capture into a_rdata/b_rdata);
// when undefined, miso is unused and the rdata outputs are constant 0.
module lms_spi_sched #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [2:0]  a_tgt,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic [2:0]  b_tgt,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic [4:0]  sen_n,
  output logic        busy,
  output logic        last_b
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [4:0]  sen_n_q, sen_n_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        busy_q, busy_d;
  logic        last_b_q, last_b_d;

  logic        div_end;
  logic        gnt_b;
  logic [2:0]  sel_tgt;
  logic [15:0] sel_wdata;
  // Strobes towards the readback datapath
  logic        cap_clr, cap_en, ld_a, ld_b;

  assign div_end = (div_q == DIV_LAST);

  // Next-state and registered-output logic for the transaction sequencer
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    sen_n_d   = sen_n_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    busy_d    = busy_q;
    last_b_d  = last_b_q;
    gnt_b     = 1'b0;
    sel_tgt   = '0;
    sel_wdata = '0;
    cap_clr   = 1'b0;
    cap_en    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // B wins only if A is not asking or A was served last
          gnt_b     = b_req && (!a_req || !last_b_q);
          sel_tgt   = gnt_b ? b_tgt : a_tgt;
          sel_wdata = gnt_b ? b_wdata : a_wdata;
          last_b_d  = gnt_b;
          sh_d      = sel_wdata;
          div_d     = '0;
          bit_d     = '0;
          busy_d    = 1'b1;
          cap_clr   = 1'b1;
          if (sel_tgt <= 3'd4) begin
            state_d = SETUP;
            sen_n_d = ~(5'b00001 << sel_tgt);
            mosi_d  = sel_wdata[15];
            sclk_d  = 1'b0;
          end else begin
            // Invalid target: skip the bus entirely, ack with zero rdata
            state_d = DONE;
            a_ack_d = !gnt_b;
            b_ack_d = gnt_b;
            ld_a    = !gnt_b;
            ld_b    = gnt_b;
          end
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            cap_en = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 4'd1;
              sh_d   = {sh_q[14:0], 1'b0};
              mosi_d = sh_q[14];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d = DONE;
          div_d   = '0;
          sen_n_d = '1;
          mosi_d  = 1'b0;
          a_ack_d = !last_b_q;
          b_ack_d = last_b_q;
          ld_a    = !last_b_q;
          ld_b    = last_b_q;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        state_d = GAP;
        div_d   = '0;
      end
      GAP: begin
        if (div_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sen_n_d = '1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      sen_n_q  <= '1;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      sen_n_q  <= sen_n_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      busy_q   <= busy_d;
      last_b_q <= last_b_d;
    end
  end

`ifdef LMS_SPI_READBACK_EN
  logic [7:0] rx_q, rx_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;

  // MISO capture on SCLK rise; rdata loads on ack (zero for invalid-target grants,
  // where clear and load coincide)
  always_comb begin
    rx_d      = rx_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (cap_clr)     rx_d = '0;
    else if (cap_en) rx_d = {rx_q[6:0], miso};
    if (ld_a) a_rdata_d = cap_clr ? '0 : rx_q;
    if (ld_b) b_rdata_d = cap_clr ? '0 : rx_q;
  end

  // Readback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q      <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      rx_q      <= rx_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
`else
  logic unused_readback;
  assign unused_readback = ^{miso, cap_clr, cap_en, ld_a, ld_b};
  assign a_rdata = '0;
  assign b_rdata = '0;
`endif

  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign sen_n  = sen_n_q;
  assign a_ack  = a_ack_q;
  assign b_ack  = b_ack_q;
  assign busy   = busy_q;
  assign last_b = last_b_q;

endmodule

// File: tb/tb_lms_spi_sched.sv
// tb_lms_spi_sched: scoreboard bench for lms_spi_sched (CLK_DIV=4).
// Stimulus pushes expected transactions; a negedge monitor reconstructs each
// transaction from the bus and compares it when an ack appears.
module tb_lms_spi_sched;
  localparam int unsigned CD   = 4;
  localparam int          XFER = 34 * CD;
`ifdef LMS_SPI_READBACK_EN
  localparam logic [7:0] RB_EXP = 8'h5A;
`else
  localparam logic [7:0] RB_EXP = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req;
  logic [2:0]  a_tgt, b_tgt;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [7:0]  a_rdata, b_rdata;
  logic        sclk, mosi, miso;
  logic [4:0]  sen_n;
  logic        busy, last_b;

  lms_spi_sched #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_tgt(a_tgt), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_tgt(b_tgt), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .sclk(sclk), .mosi(mosi), .miso(miso), .sen_n(sen_n), .busy(busy), .last_b(last_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port_b;
    logic [2:0]  tgt;
    logic [15:0] wdata;
    int          ack_cyc;   // absolute ack cycle, -1 = not checked
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acks   = 0;
  int rises  = 0;

  // MISO word returned by the slave model, MSB first; low byte is the readback
  logic [15:0] miso_pat = 16'h3C5A;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: rebuild each transaction from the pins, compare on ack
  logic        prev_busy = 1'b0, prev_sclk = 1'b0;
  int          start_cyc = 0, sen_cnt = 0;
  logic [15:0] mw = '0;
  logic [4:0]  sen_seen = '1;
  logic        sen_bad = 1'b0;
  always @(negedge clk) begin
    exp_t        e;
    bit          valid;
    logic [4:0]  es;
    if (busy && !prev_busy) begin
      start_cyc = cyc; rises = 0; mw = '0; sen_cnt = 0; sen_seen = '1; sen_bad = 1'b0;
    end
    if (sclk && !prev_sclk) begin
      rises = rises + 1;
      mw    = {mw[14:0], mosi};
    end
    if (sen_n != 5'h1F) begin
      sen_cnt = sen_cnt + 1;
      if (sen_seen == 5'h1F) sen_seen = sen_n;
      else if (sen_n != sen_seen) sen_bad = 1'b1;
    end
    miso = (rises < 16) ? miso_pat[4'(15 - rises)] : 1'b0;
    if (a_ack || b_ack) begin
      acks = acks + 1;
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, a_ack, b_ack}, 32'd0);
      end else begin
        e     = sb.pop_front();
        valid = (e.tgt <= 3'd4);
        es    = valid ? (5'h1F & ~(5'd1 << e.tgt)) : 5'h1F;
        chk("ack_port",   {30'd0, a_ack, b_ack}, e.port_b ? 32'd1 : 32'd2);
        chk("last_b",     32'(last_b), 32'(e.port_b));
        chk("rdata",      32'(e.port_b ? b_rdata : a_rdata), valid ? 32'(RB_EXP) : 32'd0);
        chk("mosi_word",  32'(mw), valid ? 32'(e.wdata) : 32'd0);
        chk("sclk_rises", rises, valid ? 32'd16 : 32'd0);
        chk("sen_cycles", sen_cnt, valid ? XFER : 0);
        chk("sen_value",  32'(sen_seen), 32'(es));
        chk("sen_stable", 32'(sen_bad), 32'd0);
        chk("latency",    cyc - start_cyc, valid ? XFER : 0);
        if (e.ack_cyc >= 0) chk("ack_cycle", cyc, e.ack_cyc);
      end
    end
    prev_busy = busy;
    prev_sclk = sclk;
  end

  task automatic wait_acks(input int target, input int budget);
    int i = 0;
    while (acks < target && i < budget) begin
      @(negedge clk);
      i = i + 1;
    end
    chk("ack_timeout", 32'(acks >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    a_tgt = '0; b_tgt = '0; a_wdata = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_sen_n",   32'(sen_n), 32'h1F);
    chk("rst_sclk",    32'(sclk), 32'd0);
    chk("rst_mosi",    32'(mosi), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_last_b",  32'(last_b), 32'd1);
    chk("rst_acks",    {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst_a_rdata", 32'(a_rdata), 32'd0);
    chk("rst_b_rdata", 32'(b_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single A write to LMS1
    a_tgt = 3'd1; a_wdata = 16'hA5C3;
    sb.push_back('{1'b0, 3'd1, 16'hA5C3, cyc + 137});
    a_req = 1'b1;
    wait_acks(1, 200);
    a_req = 1'b0;
    repeat (10) @(negedge clk);

    // Readback from LMS2
    a_tgt = 3'd2; a_wdata = 16'h1234;
    sb.push_back('{1'b0, 3'd2, 16'h1234, cyc + 137});
    a_req = 1'b1;
    wait_acks(2, 200);
    a_req = 1'b0;
    repeat (10) @(negedge clk);

    // Both requesting across reset exit: A,B,A,B back to back
    rst = 1'b1;
    a_req = 1'b1; b_req = 1'b1;
    a_tgt = 3'd3; a_wdata = 16'hF00F;
    b_tgt = 3'd4; b_wdata = 16'h0FF0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = cyc;
    sb.push_back('{1'b0, 3'd3, 16'hF00F, k + 137});
    sb.push_back('{1'b1, 3'd4, 16'h0FF0, k + 279});
    sb.push_back('{1'b0, 3'd3, 16'hF00F, k + 421});
    sb.push_back('{1'b1, 3'd4, 16'h0FF0, k + 563});
    wait_acks(6, 800);
    a_req = 1'b0; b_req = 1'b0;
    repeat (10) @(negedge clk);

    // Invalid target on B
    b_tgt = 3'd6; b_wdata = 16'hFFFF;
    sb.push_back('{1'b1, 3'd6, 16'hFFFF, cyc + 1});
    b_req = 1'b1;
    wait_acks(7, 20);
    b_req = 1'b0;
    repeat (10) @(negedge clk);

    // Reset at the 8th SCLK rise, then the held A request re-runs in full
    a_tgt = 3'd0; a_wdata = 16'h8001;
    sb.push_back('{1'b0, 3'd0, 16'h8001, -1});
    a_req = 1'b1;
    begin
      int i = 0;
      while (!(busy && rises >= 8) && i < 200) begin
        @(negedge clk);
        i = i + 1;
      end
      chk("rise8_timeout", 32'(busy && rises >= 8), 32'd1);
    end
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    chk("abort_sen_n",   32'(sen_n), 32'h1F);
    chk("abort_sclk",    32'(sclk), 32'd0);
    chk("abort_busy",    32'(busy), 32'd0);
    chk("abort_mosi",    32'(mosi), 32'd0);
    chk("abort_acks",    {30'd0, a_ack, b_ack}, 32'd0);
    chk("abort_a_rdata", 32'(a_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{1'b0, 3'd0, 16'h8001, cyc + 137});
    wait_acks(8, 200);
    a_req = 1'b0;
    repeat (10) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
